// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - button conditioner signal bundle
// Ports (master = conditioner, slave = button source / consumer):
//   i_btn       raw buttons, active-high, asynchronous to clk
//   o_btn_level debounced level
//   o_btn_rise  1-clk pulse on debounced 0->1
//   o_btn_fall  1-clk pulse on debounced 1->0
//   o_btn_long  1-clk pulse, once per press, after a long hold
interface btn_debounce_if #(
   parameter int N_BTN = 2
);
   logic [N_BTN-1:0] i_btn;
   logic [N_BTN-1:0] o_btn_level;
   logic [N_BTN-1:0] o_btn_rise;
   logic [N_BTN-1:0] o_btn_fall;
   logic [N_BTN-1:0] o_btn_long;

   modport master (
      input  i_btn,
      output o_btn_level,
      output o_btn_rise,
      output o_btn_fall,
      output o_btn_long
   );

   modport slave (
      output i_btn,
      input  o_btn_level,
      input  o_btn_rise,
      input  o_btn_fall,
      input  o_btn_long
   );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - multi-channel push-button debouncer with edge and long-press pulses
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  btn_debounce_if.master: raw buttons in; level, rise, fall, long out
module btn_debounce #(
   parameter int N_BTN      = 2,
   parameter int TICK_DIV   = 100_000,
   parameter int DEPTH      = 8,
   parameter int LONG_TICKS = 1000
) (
   input  logic           clk,
   input  logic           rst,
   btn_debounce_if.master bus
);
   localparam int CW = $clog2(TICK_DIV);
   localparam int HW = $clog2(LONG_TICKS + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
   localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_TICKS - 1);

   logic [CW-1:0]    tick_cnt;
   logic             tick;
   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;
   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] level_d;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] fall;
   logic [N_BTN-1:0] long_p;

   // One shared sample strobe for all channels.
   assign tick = (tick_cnt == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.i_btn;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic [DEPTH-1:0] sh;
      logic [HW-1:0]    hold;
      logic             lvl_q;
      logic             long_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sh <= '0;
         end else if (tick) begin
            sh <= {sh[DEPTH-2:0], sync2[i]};
         end
      end

      // Hysteresis: only a unanimous window moves the level.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            lvl_q <= 1'b0;
         end else if (&sh) begin
            lvl_q <= 1'b1;
         end else if (~|sh) begin
            lvl_q <= 1'b0;
         end
      end

      // Saturating hold counter: the pulse fires only on the tick that reaches
      // the limit, so a single press can never produce a second long pulse.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            hold   <= '0;
            long_q <= 1'b0;
         end else begin
            long_q <= lvl_q && tick && (hold == HOLD_PRE);
            if (!lvl_q) begin
               hold <= '0;
            end else if (tick && (hold != HOLD_MAX)) begin
               hold <= hold + HW'(1);
            end
         end
      end

      assign level[i]  = lvl_q;
      assign long_p[i] = long_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= '0;
         rise    <= '0;
         fall    <= '0;
      end else begin
         level_d <= level;
         rise    <= level & ~level_d;
         fall    <= ~level & level_d;
      end
   end

   assign bus.o_btn_level = level;
   assign bus.o_btn_rise  = rise;
   assign bus.o_btn_fall  = fall;
   assign bus.o_btn_long  = long_p;
endmodule
